serial_add_ctrl: RTL

//  Bit-serial adder sequencer. Accepts two WIDTH-bit operands plus carry-in

---
 rtl/serial_add_pkg.sv | 23 ++
 rtl/serial_add_ctrl_if.sv | 32 +++
 rtl/halfadder.sv | 17 +
 rtl/serial_fa.sv | 24 ++
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
//------------------------------------------------------------------------------
// serial_add_pkg: shared state encoding and sizing helper for the serial adder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_RSVD = 2'd3
   } state_e;

   // One extra bit so the bit counter can always hold WIDTH-1, even at WIDTH=1.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
//------------------------------------------------------------------------------
// serial_add_ctrl_if: operand and result handshake bundle for serial_add_ctrl.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

`default_nettype wire

// File: rtl/halfadder.sv
//------------------------------------------------------------------------------
// halfadder: single-bit half adder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module halfadder (
   input  wire logic a_i,
   input  wire logic b_i,
   output logic      s_o,
   output logic      c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

`default_nettype wire

// File: rtl/serial_fa.sv
//------------------------------------------------------------------------------
// serial_fa: full adder cell built from two half adders and an OR of carries.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_fa (
   input  wire logic a_i,
   input  wire logic b_i,
   input  wire logic c_i,
   output logic      s_o,
   output logic      c_o
);
   logic s0;
   logic c0;
   logic c1;

   halfadder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
   halfadder u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

   assign c_o = c0 | c1;
endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// serial_add_ctrl: bit-serial adder sequencer, LSB first through one FA cell.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   serial_add_ctrl_if.slave   bus
);
   localparam int               CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] sum_shift;

   serial_fa u_fa (
      .a_i (a_sr_q[0]),
      .b_i (b_sr_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   // New sum bit enters at the MSB so bit 0 lands at the LSB after WIDTH edges.
   generate
      if (WIDTH == 1) begin : g_shift_w1
         assign sum_shift = fa_s;
      end else begin : g_shift_wn
         assign sum_shift = {fa_s, sum_sr_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d       = state_q;
      a_sr_d        = a_sr_q;
      b_sr_d        = b_sr_q;
      sum_sr_d      = sum_sr_q;
      carry_d       = carry_q;
      count_d       = count_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      bus.sum       = '0;
      bus.cout      = 1'b0;

      case (state_q)
         ST_RUN: begin
            bus.busy = 1'b1;
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = sum_shift;
            carry_d  = fa_c;
            if (count_q == LAST) begin
               state_d = ST_DONE;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            bus.sum       = sum_sr_q;
            bus.cout      = carry_q;
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            // ST_RSVD behaves as IDLE and falls back into it.
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               a_sr_d   = bus.a;
               b_sr_d   = bus.b;
               carry_d  = bus.cin;
               sum_sr_d = '0;
               count_d  = '0;
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         count_q  <= count_d;
      end
   end
endmodule

`default_nettype wire
